// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Instruction/data arbiter for a single-port memory with
//               anti-starvation of the fetch port.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_if,
    output logic              stall_mem
);

    localparam int STARVE_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] I_BUSY = 2'd1;
    localparam logic [1:0] D_BUSY = 2'd2;
    localparam logic [1:0] RESP   = 2'd3;

    logic [1:0]          state_q,     state_d;
    logic [STARVE_W-1:0] starve_q,    starve_d;
    logic [ADDR_W-1:0]   addr_q,      addr_d;
    logic                we_q,        we_d;
    logic [DATA_W-1:0]   wdata_q,     wdata_d;
    logic                mem_req_q,   mem_req_d;
    logic                if_rvalid_q, if_rvalid_d;
    logic                d_rvalid_q,  d_rvalid_d;
    logic [DATA_W-1:0]   if_rdata_q,  if_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q,   d_rdata_d;

    logic d_win;
    logic i_ack;
    logic d_ack;

    always_comb begin
        // Data side wins unless the fetch side has waited through STARVE_MAX data grants
        d_win  = d_req && (!if_req || (starve_q < STARVE_LIM));
        d_gnt  = !rst && (state_q == IDLE) && d_win;
        if_gnt = !rst && (state_q == IDLE) && !d_win && if_req;
        i_ack  = mem_ack && (state_q == I_BUSY);
        d_ack  = mem_ack && (state_q == D_BUSY);

        state_d     = state_q;
        starve_d    = starve_q;
        addr_d      = addr_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        mem_req_d   = (mem_req_q && !(i_ack || d_ack)) || if_gnt || d_gnt;
        if_rvalid_d = i_ack;
        d_rvalid_d  = d_ack;
        if_rdata_d  = i_ack ? mem_rdata : if_rdata_q;
        d_rdata_d   = (d_ack && !we_q) ? mem_rdata : d_rdata_q;

        case (state_q)
            IDLE: begin
                if (d_gnt) begin
                    state_d = D_BUSY;
                    addr_d  = d_addr;
                    we_d    = d_we;
                    wdata_d = d_wdata;
                    if (if_req && (starve_q != STARVE_LIM)) begin
                        starve_d = starve_q + STARVE_W'(1);
                    end
                end else if (if_gnt) begin
                    state_d  = I_BUSY;
                    addr_d   = if_addr;
                    we_d     = 1'b0;
                    wdata_d  = '0;
                    starve_d = '0;
                end
            end
            I_BUSY, D_BUSY: begin
                if (mem_ack) begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            starve_q    <= '0;
            addr_q      <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            mem_req_q   <= 1'b0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            mem_req_q   <= mem_req_d;
            if_rvalid_q <= if_rvalid_d;
            d_rvalid_q  <= d_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign if_rvalid = if_rvalid_q;
    assign d_rvalid  = d_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign stall_if  = if_req & ~if_rvalid_q;
    assign stall_mem = d_req & ~d_rvalid_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Directed and randomized checks of mem_arbiter against a
//               transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int STARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, d_req, d_we, mem_ack;
    logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
    logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_req, mem_we, stall_if, stall_mem;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .stall_if(stall_if), .stall_mem(stall_mem)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: one outstanding transaction plus a pending response
    bit          m_busy = 0, m_own_d = 0, m_we = 0, m_resp = 0, m_resp_d = 0;
    logic [31:0] m_addr = 0, m_wdata = 0, m_if_rdata = 0, m_d_rdata = 0;
    int          m_starve = 0;
    int          age = 0, lat = 1, lat_cfg = 1;
    bit          force_ack = 0, rand_data = 0;
    logic [31:0] ack_data = 0;
    bit          e_ig, e_dg, e_irv, e_drv, can_grant, want_d;
    bit          obs_ig, obs_dg, obs_irv, obs_drv, obs_stall_if, obs_mem_req;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: inputs are already applied at posedge+1
    task automatic cycle();
        mem_ack   = force_ack || (m_busy && age >= lat);
        mem_rdata = rand_data ? $urandom : ack_data;
        #3;
        can_grant = !rst && !m_busy && !m_resp;
        want_d    = d_req && (!if_req || m_starve < STARVE_MAX);
        e_dg      = can_grant && want_d;
        e_ig      = can_grant && !want_d && if_req;
        e_irv     = m_resp && !m_resp_d;
        e_drv     = m_resp && m_resp_d;
        obs_ig = if_gnt; obs_dg = d_gnt; obs_irv = if_rvalid; obs_drv = d_rvalid;
        obs_stall_if = stall_if; obs_mem_req = mem_req;
        chk("if_gnt", if_gnt, e_ig);
        chk("d_gnt", d_gnt, e_dg);
        chk("if_rvalid", if_rvalid, e_irv);
        chk("d_rvalid", d_rvalid, e_drv);
        chk("mem_req", mem_req, m_busy);
        if (m_busy) begin
            chk("mem_addr", mem_addr, m_addr);
            chk("mem_we", mem_we, m_we);
            if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
        end
        chk("if_rdata", if_rdata, m_if_rdata);
        chk("d_rdata", d_rdata, m_d_rdata);
        chk("stall_if", stall_if, if_req && !e_irv);
        chk("stall_mem", stall_mem, d_req && !e_drv);
        @(posedge clk);
        if (rst) begin
            m_busy = 0; m_resp = 0; m_starve = 0; m_if_rdata = 0; m_d_rdata = 0;
        end else begin
            m_resp = 0;
            if (m_busy && mem_ack) begin
                m_resp   = 1;
                m_resp_d = m_own_d;
                if (!m_own_d) m_if_rdata = mem_rdata;
                else if (!m_we) m_d_rdata = mem_rdata;
                m_busy = 0;
            end else if (m_busy) begin
                age++;
            end
            if (e_dg) begin
                m_busy = 1; m_own_d = 1; m_we = d_we; m_addr = d_addr; m_wdata = d_wdata;
                if (if_req && m_starve < STARVE_MAX) m_starve++;
            end else if (e_ig) begin
                m_busy = 1; m_own_d = 0; m_we = 0; m_addr = if_addr;
                m_starve = 0;
            end
            if (e_dg || e_ig) begin
                age = 1;
                lat = (lat_cfg != 0) ? lat_cfg : $urandom_range(1, 4);
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        if_req = 0; d_req = 0; d_we = 0; force_ack = 0;
    endtask

    initial begin
        string exp_order;
        byte   got[$];
        bit    seen;
        bit    i_on, i_g, d_on, d_g, last_rst;

        rst = 1; idle_inputs();
        if_addr = 0; d_addr = 0; d_wdata = 0; mem_ack = 0; mem_rdata = 0;
        @(posedge clk); @(posedge clk); #1;

        // Reset state with both requests present: no grants
        if_req = 1; d_req = 1;
        cycle();
        chk("rst_no_ig", obs_ig, 0);
        chk("rst_no_dg", obs_dg, 0);
        rst = 0; idle_inputs();
        cycle();

        // Single fetch, memory answers in the second mem_req cycle
        lat_cfg = 2; ack_data = 32'hDEADBEEF;
        if_req = 1; if_addr = 32'h100;
        cycle();
        chk("fetch_gnt_N", obs_ig, 1);
        chk("fetch_stall_N", obs_stall_if, 1);
        cycle();
        chk("fetch_mreq_N1", obs_mem_req, 1);
        cycle();
        chk("fetch_mreq_N2", obs_mem_req, 1);
        chk("fetch_stall_N2", obs_stall_if, 1);
        cycle();
        chk("fetch_rv_N3", obs_irv, 1);
        chk("fetch_rdata", if_rdata, 32'hDEADBEEF);
        idle_inputs();
        cycle();

        // Data write
        lat_cfg = 1;
        d_req = 1; d_we = 1; d_addr = 32'h20; d_wdata = 32'h55;
        cycle();
        chk("wr_gnt", obs_dg, 1);
        cycle();
        chk("wr_mem_we", mem_we, 1);
        chk("wr_mem_wdata", mem_wdata, 32'h55);
        cycle();
        chk("wr_rv", obs_drv, 1);
        chk("wr_rdata_kept", d_rdata, 0);
        idle_inputs();
        cycle();

        // Contention with both requests held
        exp_order = "DDDDIDDDDI";
        if_req = 1; if_addr = 32'h300; d_req = 1; d_we = 0; d_addr = 32'h40;
        rand_data = 1;
        for (int c = 0; c < 60 && got.size() < 10; c++) begin
            cycle();
            if (obs_dg) got.push_back("D");
            if (obs_ig) got.push_back("I");
        end
        chk("order_len", got.size() >= 10, 1);
        for (int k = 0; k < 10 && k < got.size(); k++) chk("order", got[k], exp_order[k]);
        idle_inputs();
        cycle(); cycle();

        // Reset while the data access is outstanding, then a late ack
        lat_cfg = 100;
        if_req = 1; d_req = 1; d_we = 0; d_addr = 32'h44;
        cycle();
        chk("rstb_gnt", obs_dg, 1);
        rst = 1;
        cycle();
        rst = 0; idle_inputs();
        cycle();
        chk("rstb_mreq_low", obs_mem_req, 0);
        chk("rstb_starve", dut.starve_q, 0);
        force_ack = 1;
        cycle();
        chk("rstb_no_drv", obs_drv, 0);
        force_ack = 0;
        cycle();
        chk("rstb_no_drv2", obs_drv, 0);

        // Stray acks while idle
        force_ack = 1;
        cycle(); cycle();
        chk("stray_no_irv", obs_irv, 0);
        chk("stray_no_drv", obs_drv, 0);
        force_ack = 0;
        cycle();

        // Back-to-back fetch
        lat_cfg = 1;
        if_req = 1; if_addr = 32'h200;
        seen = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            cycle();
            seen = obs_irv;
        end
        chk("b2b_rv_seen", seen, 1);
        if_addr = 32'h204;
        cycle();
        chk("b2b_gnt", obs_ig, 1);
        for (int c = 0; c < 4; c++) cycle();
        idle_inputs();
        cycle(); cycle();

        // Randomized traffic with random latencies, stray acks and resets
        lat_cfg = 0;
        i_on = 0; i_g = 0; d_on = 0; d_g = 0; last_rst = 0;
        for (int c = 0; c < 3000; c++) begin
            if (last_rst) begin i_on = 0; i_g = 0; d_on = 0; d_g = 0; end
            if (i_on) begin
                if (e_irv) begin
                    i_g = 0;
                    if ($urandom_range(0, 1) == 1) if_addr = $urandom; else i_on = 0;
                end else if (!i_g && $urandom_range(0, 7) == 0) i_on = 0;
            end else if ($urandom_range(0, 2) == 0) begin
                i_on = 1; i_g = 0; if_addr = $urandom;
            end
            if (d_on) begin
                if (e_drv) begin
                    d_g = 0;
                    if ($urandom_range(0, 1) == 1) begin
                        d_we = $urandom_range(0, 1) == 1; d_addr = $urandom; d_wdata = $urandom;
                    end else d_on = 0;
                end else if (!d_g && $urandom_range(0, 7) == 0) d_on = 0;
            end else if ($urandom_range(0, 1) == 0) begin
                d_on = 1; d_g = 0;
                d_we = $urandom_range(0, 1) == 1; d_addr = $urandom; d_wdata = $urandom;
            end
            rst       = ($urandom_range(0, 199) == 0);
            force_ack = !m_busy && ($urandom_range(0, 9) == 0);
            if_req    = i_on;
            d_req     = d_on;
            cycle();
            if (e_ig) i_g = 1;
            if (e_dg) d_g = 1;
            last_rst = rst;
        end
        rst = 0; idle_inputs();
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The module SHALL use parameter ADDR_W, default 32, as the address width.
REQ-002 The module SHALL use parameter DATA_W, default 32, as the data width.
REQ-003 The module SHALL use parameter STARVE_MAX, default 4, as the maximum number of consecutive data-side grants while a fetch is waiting.
REQ-004 The module SHALL have one clock and a synchronous active-high reset, with the ports listed below.
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; held with if_addr until if_rvalid
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  fetch request accepted
- if_rvalid  out  1  fetch data valid, one-cycle pulse
- if_rdata  out  DATA_W  fetch data
- d_req  in  1  data request; held with d_we, d_addr and d_wdata until d_rvalid
- d_we  in  1  1 = write, 0 = read
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  write data
- d_gnt  out  1  data request accepted
- d_rvalid  out  1  data access complete, one-cycle pulse
- d_rdata  out  DATA_W  load data
- mem_req  out  1  single-port memory request
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_ack  in  1  memory completion pulse; mem_rdata valid in the same cycle
- mem_rdata  in  DATA_W  memory read data
- stall_if  out  1  freeze the fetch stage
- stall_mem  out  1  freeze the memory stage

Function
REQ-005 The FSM SHALL have four states: IDLE, I_BUSY, D_BUSY and RESP.
REQ-006 In IDLE, the arbiter SHALL grant D when d_req=1 and either if_req=0 or starve_cnt<STARVE_MAX.
REQ-007 In IDLE, the arbiter SHALL grant I when a D grant is not made and if_req=1.
REQ-008 A grant SHALL be a combinational pulse on if_gnt or d_gnt in the IDLE cycle N.
REQ-009 At edge N, the grant SHALL latch the address, we and wdata into registers and move the FSM to I_BUSY or D_BUSY.
REQ-010 mem_req SHALL be registered and asserted from cycle N+1.
REQ-011 mem_req SHALL stay asserted, with mem_addr, mem_we and mem_wdata stable, until the cycle in which mem_ack=1 is sampled.
REQ-012 mem_we SHALL be 0 for fetch accesses.
REQ-013 When mem_ack=1 is sampled in I_BUSY or D_BUSY at cycle M, the FSM SHALL move to RESP.
REQ-014 In cycle M+1 (RESP), the owner's rvalid SHALL pulse for exactly one cycle.
REQ-015 In cycle M+1, if_rdata or d_rdata SHALL hold mem_rdata as registered at edge M.
REQ-016 For a write, d_rvalid SHALL still pulse and d_rdata SHALL keep its previous value.
REQ-017 RESP SHALL always go to IDLE, and no grant SHALL be made in RESP.
REQ-018 The minimum occupancy per access SHALL be 3 cycles: grant, mem_ack at N+1, then RESP.
REQ-019 mem_ack in IDLE or RESP SHALL be ignored, with no state change and no rvalid.
REQ-020 starve_cnt SHALL be ceil(log2(STARVE_MAX+1)) bits wide.
REQ-021 starve_cnt SHALL increment, saturating at STARVE_MAX, on a D grant while if_req=1.
REQ-022 starve_cnt SHALL clear to 0 on any I grant and hold otherwise.
REQ-023 When both requests are present and starve_cnt==STARVE_MAX, I SHALL win.
REQ-024 stall_if SHALL equal if_req & ~if_rvalid, combinationally.
REQ-025 stall_mem SHALL equal d_req & ~d_rvalid, combinationally.
REQ-026 A req still high in the cycle after rvalid SHALL be treated as a new request.
REQ-027 Requests dropped before grant SHALL be legal and SHALL cause no side effects.

Reset
REQ-028 While rst=1 at an edge, the FSM SHALL go to IDLE and starve_cnt, the latched address, latched we and latched wdata SHALL go to 0.
REQ-029 While rst=1 at an edge, if_rdata and d_rdata SHALL go to 0 and mem_req, if_rvalid and d_rvalid SHALL go to 0.
REQ-030 A reset during I_BUSY, D_BUSY or RESP SHALL abandon the access: mem_req low from the next cycle and no rvalid for it.
REQ-031 An outstanding mem_ack arriving after reset SHALL be ignored.
REQ-032 Combinational if_gnt and d_gnt SHALL be 0 while rst=1.

Verification
REQ-033 Single fetch: if_req=1, if_addr=0x100, mem_ack 2 cycles after mem_req with mem_rdata=0xDEADBEEF -> if_gnt at N, mem_req cycles N+1..N+2, if_rvalid at N+3 with if_rdata=0xDEADBEEF, stall_if=1 from N to N+2.
REQ-034 Write: d_req=1, d_we=1, d_addr=0x20, d_wdata=0x55 -> mem_we=1 and mem_wdata=0x55 while mem_req is high, then d_rvalid pulses and d_rdata is unchanged.
REQ-035 Contention: if_req and d_req held continuously with STARVE_MAX=4 -> grant order D,D,D,D,I,D,D,D,D,I.
REQ-036 Reset in D_BUSY: rst at cycle N+1, then mem_ack at N+3 -> mem_req=0 from N+2, no d_rvalid, FSM in IDLE, starve_cnt=0.
REQ-037 Stray mem_ack while in IDLE -> no rvalid, no state change.
REQ-038 Back-to-back fetch: if_req held through if_rvalid with a new address -> second if_gnt exactly one cycle after if_rvalid.
